regfile_wb_ctrl: RTL and testbench
==================================

Name: regfile_wb_ctrl

Overview:
- Write-back controller and scoreboard in front of the 32x32 register file (x0 hardwired zero; combinational read; synchronous write).
- Merges two write-back sources onto the single write port:
  - ALU: single-cycle, highest priority, never back-pressured.
  - LSU: multi-cycle, valid/ready.
- Tracks registers with in-flight long-latency (LSU) results and raises a decode stall on RAW/WAW hazards.
- Starvation guard forces an ALU bubble so the LSU cannot wait forever.

Parameters:
- STARVE_LIMIT, 4, consecutive LSU wait cycles before alu_hold is asserted (1..15).
- CNT_W, 4, width of the LSU wait counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- iss_valid  in  1  an instruction issues this cycle.
- iss_long  in  1  the issuing instruction writes back via the LSU.
- iss_rd  in  5  destination of the issuing instruction.
- dec_valid  in  1  decode holds a valid instruction.
- dec_long  in  1  the decoded instruction is long-latency.
- dec_rs1  in  5  decode source 1.
- dec_rs2  in  5  decode source 2.
- dec_rd  in  5  decode destination.
- dec_stall  out  1  hazard stall to decode (combinational).
- alu_we  in  1  ALU write-back valid.
- alu_rd  in  5  ALU destination.
- alu_data  in  32  ALU result.
- alu_hold  out  1  ALU must not write next slot (combinational from state).
- lsu_valid  in  1  LSU write-back request.
- lsu_rd  in  5  LSU destination.
- lsu_data  in  32  LSU result.
- lsu_ready  out  1  LSU request accepted this cycle.
- rf_we  out  1  register-file write enable (registered).
- rf_rd  out  5  register-file write address (registered).
- rf_rd_data  out  32  register-file write data (registered).
- busy  out  32  scoreboard vector; bit 0 always 0.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset: synchronous active-high; rst sampled on the rising edge of clk.
  - rf_we=0, rf_rd=0, rf_rd_data=0, busy=0, wait counter=0, err=0.
  - Combinational outputs evaluate from the reset state: dec_stall=0, alu_hold=0, lsu_ready=1.
  - Reset mid-operation discards pending scoreboard bits and any LSU request in progress.
- ALU write:
  - alu_eff = alu_we && alu_rd!=0.
  - lsu_ready = !alu_eff. An ALU write to x0 leaves the port free.
- Handshake:
  - LSU transfer occurs when lsu_valid && lsu_ready.
  - LSU must hold lsu_rd/lsu_data stable while lsu_valid && !lsu_ready.
- Output register, next cycle:
  - alu_eff: rf_we=1, rf_rd=alu_rd, rf_rd_data=alu_data.
  - else LSU transfer: rf_we=1, rf_rd=lsu_rd, rf_rd_data=lsu_data.
  - else rf_we=0, with rf_rd and rf_rd_data held.
  - Latency: source to register-file write is 1 cycle registered, committed at the following edge.
- Scoreboard:
  - Set busy[iss_rd] when iss_valid && iss_long && iss_rd!=0.
  - Clear busy[lsu_rd] on an LSU transfer.
  - Set and clear of the same index in one cycle: set wins.
  - busy[0] is never set.
- dec_stall is asserted when dec_valid and any of:
  - busy[dec_rs1] (rs1!=0)
  - busy[dec_rs2] (rs2!=0)
  - rf_we && rf_rd==dec_rs1 && rs1!=0 (pending write not yet visible; same for rs2)
  - dec_long && busy[dec_rd] && dec_rd!=0 (WAW)
- Starvation guard:
  - Counter increments (saturating at STARVE_LIMIT) when lsu_valid && !lsu_ready.
  - Counter clears on an LSU transfer or when !lsu_valid.
  - alu_hold = lsu_valid && cnt==STARVE_LIMIT.
  - Upstream keeps alu_we=0 while alu_hold=1, so the LSU is accepted that cycle.
- err (sticky until rst) is set on either:
  - alu_eff while alu_hold=1 (the write is still performed, ALU priority kept);
  - an LSU transfer whose lsu_rd!=0 and busy[lsu_rd]=0.

Test Plan:
- Reset, then idle -> rf_we=0, busy=0, lsu_ready=1, dec_stall=0, err=0.
- ALU alu_we=1, rd=5, data=0xDEADBEEF -> next cycle rf_we=1, rf_rd=5, rf_rd_data=0xDEADBEEF. Decode rs1=5 that cycle -> dec_stall=1; the cycle after -> 0.
- Issue long op rd=7 -> busy[7]=1. Decode rs2=7 stalls. LSU valid rd=7, data=0x1234 with no ALU write -> lsu_ready=1, busy[7] clears, rf write of 0x1234 one cycle later.
- LSU rd=3 valid while ALU writes every cycle (STARVE_LIMIT=4) -> lsu_ready=0 for 4 cycles, alu_hold=1 on the 5th. ALU idles that cycle -> LSU accepted, counter clears.
- Same-cycle issue long rd=9 and LSU completion rd=9 (busy[9]=1 beforehand) -> busy[9] remains 1. LSU completion to rd=12 (not busy) -> err=1, stays 1 until rst.
- ALU write to rd=0 concurrent with LSU rd=4 -> lsu_ready=1, LSU written; rf_rd=4. Assert rst with busy nonzero -> busy=0, rf_we=0 next cycle.

Source files
------------

// File: rtl/regfile_wb_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_wb_ctrl                                                          |
// | Write-back arbiter (ALU over LSU) and long-latency scoreboard for the    |
// | 32x32 register file.                                                     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module regfile_wb_ctrl #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        iss_valid_i,
  input  logic        iss_long_i,
  input  logic [4:0]  iss_rd_i,

  input  logic        dec_valid_i,
  input  logic        dec_long_i,
  input  logic [4:0]  dec_rs1_i,
  input  logic [4:0]  dec_rs2_i,
  input  logic [4:0]  dec_rd_i,
  output logic        dec_stall_o,

  input  logic        alu_we_i,
  input  logic [4:0]  alu_rd_i,
  input  logic [31:0] alu_data_i,
  output logic        alu_hold_o,

  input  logic        lsu_valid_i,
  input  logic [4:0]  lsu_rd_i,
  input  logic [31:0] lsu_data_i,
  output logic        lsu_ready_o,

  output logic        rf_we_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_data_o,
  output logic [31:0] busy_o,
  output logic        err_o
);

  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

  logic        rf_we_q,   rf_we_d;
  logic [4:0]  rf_rd_q,   rf_rd_d;
  logic [31:0] rf_data_q, rf_data_d;
  logic [31:0] busy_q,    busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        err_q,     err_d;

  logic w_alu_eff;
  logic w_xfer;
  logic w_set;
  logic w_hold;
  logic w_rs1_haz;
  logic w_rs2_haz;
  logic w_waw_haz;
  logic w_lsu_orphan;

  // A write to x0 is a no-op and must not steal the port from the LSU.
  assign w_alu_eff    = alu_we_i && (alu_rd_i != 5'd0);
  assign lsu_ready_o  = !w_alu_eff;
  assign w_xfer       = lsu_valid_i && lsu_ready_o;
  assign w_set        = iss_valid_i && iss_long_i && (iss_rd_i != 5'd0);
  assign w_hold       = lsu_valid_i && (cnt_q == C_LIMIT);
  assign alu_hold_o   = w_hold;
  assign w_lsu_orphan = w_xfer && (lsu_rd_i != 5'd0) && !busy_q[lsu_rd_i];

  // A write registered this cycle lands in the array at the next edge,
  // so a reader in decode would still see the stale value.
  assign w_rs1_haz = (dec_rs1_i != 5'd0) &&
                     (busy_q[dec_rs1_i] || (rf_we_q && (rf_rd_q == dec_rs1_i)));
  assign w_rs2_haz = (dec_rs2_i != 5'd0) &&
                     (busy_q[dec_rs2_i] || (rf_we_q && (rf_rd_q == dec_rs2_i)));
  assign w_waw_haz = dec_long_i && (dec_rd_i != 5'd0) && busy_q[dec_rd_i];

  assign dec_stall_o = dec_valid_i && (w_rs1_haz || w_rs2_haz || w_waw_haz);

  always_comb begin
    rf_we_d   = 1'b0;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (w_alu_eff) begin
      rf_we_d   = 1'b1;
      rf_rd_d   = alu_rd_i;
      rf_data_d = alu_data_i;
    end else if (w_xfer) begin
      rf_we_d   = 1'b1;
      rf_rd_d   = lsu_rd_i;
      rf_data_d = lsu_data_i;
    end
  end

  // Clear is applied before set so a same-index issue keeps the bit.
  always_comb begin
    busy_d = busy_q;
    if (w_xfer) begin
      busy_d[lsu_rd_i] = 1'b0;
    end
    if (w_set) begin
      busy_d[iss_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!lsu_valid_i || w_xfer) begin
      cnt_d = '0;
    end else if (cnt_q != C_LIMIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign err_d = err_q || (w_alu_eff && w_hold) || w_lsu_orphan;

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q   <= 1'b0;
      rf_rd_q   <= 5'd0;
      rf_data_q <= 32'd0;
      busy_q    <= 32'd0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      rf_we_q   <= rf_we_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign rf_we_o      = rf_we_q;
  assign rf_rd_o      = rf_rd_q;
  assign rf_rd_data_o = rf_data_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_wb_ctrl                                                       |
// | Directed scenarios plus randomized traffic against a behavioural model.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_regfile_wb_ctrl;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid, iss_long;
  logic [4:0]  iss_rd;
  logic        dec_valid, dec_long;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_stall;
  logic        alu_we;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_hold;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_rd_data;
  logic [31:0] busy;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .iss_valid_i(iss_valid), .iss_long_i(iss_long), .iss_rd_i(iss_rd),
    .dec_valid_i(dec_valid), .dec_long_i(dec_long), .dec_rs1_i(dec_rs1),
    .dec_rs2_i(dec_rs2), .dec_rd_i(dec_rd), .dec_stall_o(dec_stall),
    .alu_we_i(alu_we), .alu_rd_i(alu_rd), .alu_data_i(alu_data), .alu_hold_o(alu_hold),
    .lsu_valid_i(lsu_valid), .lsu_rd_i(lsu_rd), .lsu_data_i(lsu_data), .lsu_ready_o(lsu_ready),
    .rf_we_o(rf_we), .rf_rd_o(rf_rd), .rf_rd_data_o(rf_rd_data),
    .busy_o(busy), .err_o(err)
  );

  task automatic idle();
    iss_valid = 0; iss_long = 0; iss_rd = 0;
    dec_valid = 0; dec_long = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    alu_we = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_long(input logic [4:0] rd);
    iss_valid = 1; iss_long = 1; iss_rd = rd;
    tick();
    iss_valid = 0; iss_long = 0; iss_rd = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we got %b want 0", rf_we); else n_pass++;
    n_checks++; if (rf_rd !== 5'd0) $display("FAIL reset_rf_rd got %0d want 0", rf_rd); else n_pass++;
    n_checks++; if (rf_rd_data !== 32'd0) $display("FAIL reset_rf_data got %h want 0", rf_rd_data); else n_pass++;
    n_checks++; if (busy !== 32'd0) $display("FAIL reset_busy got %h want 0", busy); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else n_pass++;
    n_checks++; if (lsu_ready !== 1'b1) $display("FAIL reset_lsu_ready got %b want 1", lsu_ready); else n_pass++;
    n_checks++; if (dec_stall !== 1'b0) $display("FAIL reset_dec_stall got %b want 0", dec_stall); else n_pass++;
    n_checks++; if (alu_hold !== 1'b0) $display("FAIL reset_alu_hold got %b want 0", alu_hold); else n_pass++;
  endtask

  task automatic test_alu_write();
    alu_we = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    #1;
    n_checks++; if (lsu_ready !== 1'b0) $display("FAIL alu_lsu_ready got %b want 0", lsu_ready); else n_pass++;
    tick();
    alu_we = 0; alu_rd = 0; alu_data = 0;
    dec_valid = 1; dec_rs1 = 5;
    #1;
    n_checks++; if (rf_we !== 1'b1) $display("FAIL alu_rf_we got %b want 1", rf_we); else n_pass++;
    n_checks++; if (rf_rd !== 5'd5) $display("FAIL alu_rf_rd got %0d want 5", rf_rd); else n_pass++;
    n_checks++; if (rf_rd_data !== 32'hDEADBEEF) $display("FAIL alu_rf_data got %h want deadbeef", rf_rd_data); else n_pass++;
    n_checks++; if (dec_stall !== 1'b1) $display("FAIL alu_pending_stall got %b want 1", dec_stall); else n_pass++;
    tick();
    n_checks++; if (dec_stall !== 1'b0) $display("FAIL alu_stall_release got %b want 0", dec_stall); else n_pass++;
    n_checks++; if (rf_rd_data !== 32'hDEADBEEF) $display("FAIL alu_data_held got %h want deadbeef", rf_rd_data); else n_pass++;
    idle();
  endtask

  task automatic test_long_op();
    issue_long(7);
    n_checks++; if (busy[7] !== 1'b1) $display("FAIL long_busy_set got %b want 1", busy[7]); else n_pass++;
    dec_valid = 1; dec_rs2 = 7;
    #1;
    n_checks++; if (dec_stall !== 1'b1) $display("FAIL long_raw_stall got %b want 1", dec_stall); else n_pass++;
    dec_valid = 0; dec_rs2 = 0;
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h1234;
    #1;
    n_checks++; if (lsu_ready !== 1'b1) $display("FAIL long_lsu_ready got %b want 1", lsu_ready); else n_pass++;
    tick();
    idle();
    n_checks++; if (busy[7] !== 1'b0) $display("FAIL long_busy_clear got %b want 0", busy[7]); else n_pass++;
    n_checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_rd_data !== 32'h1234)
      $display("FAIL long_rf_write got we=%b rd=%0d data=%h want 1/7/1234", rf_we, rf_rd, rf_rd_data); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL long_err got %b want 0", err); else n_pass++;
  endtask

  task automatic test_starvation();
    issue_long(3);
    lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h0BAD_F00D;
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      alu_we = 1; alu_rd = 10; alu_data = 32'(i);
      #1;
      n_checks++; if (lsu_ready !== 1'b0 || alu_hold !== 1'b0)
        $display("FAIL starve_wait%0d got ready=%b hold=%b want 0/0", i, lsu_ready, alu_hold); else n_pass++;
      tick();
    end
    alu_we = 0; alu_rd = 0;
    #1;
    n_checks++; if (alu_hold !== 1'b1 || lsu_ready !== 1'b1)
      $display("FAIL starve_hold got hold=%b ready=%b want 1/1", alu_hold, lsu_ready); else n_pass++;
    tick();
    n_checks++; if (rf_rd !== 5'd3 || rf_rd_data !== 32'h0BAD_F00D)
      $display("FAIL starve_lsu_write got rd=%0d data=%h want 3/0badf00d", rf_rd, rf_rd_data); else n_pass++;
    alu_we = 1; alu_rd = 11;
    #1;
    n_checks++; if (alu_hold !== 1'b0) $display("FAIL starve_cnt_clear got %b want 0", alu_hold); else n_pass++;
    idle();
    n_checks++; if (err !== 1'b0) $display("FAIL starve_err got %b want 0", err); else n_pass++;
  endtask

  task automatic test_set_wins_err();
    issue_long(9);
    iss_valid = 1; iss_long = 1; iss_rd = 9;
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99;
    tick();
    idle();
    n_checks++; if (busy[9] !== 1'b1) $display("FAIL set_wins got %b want 1", busy[9]); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL set_wins_err got %b want 0", err); else n_pass++;
    lsu_valid = 1; lsu_rd = 12; lsu_data = 32'h12;
    tick();
    idle();
    n_checks++; if (err !== 1'b1) $display("FAIL orphan_err got %b want 1", err); else n_pass++;
    tick(); tick(); tick();
    n_checks++; if (err !== 1'b1) $display("FAIL err_sticky got %b want 1", err); else n_pass++;
  endtask

  task automatic test_x0_and_reset();
    issue_long(4);
    alu_we = 1; alu_rd = 0; alu_data = 32'hFFFF_FFFF;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 32'hAA55;
    #1;
    n_checks++; if (lsu_ready !== 1'b1) $display("FAIL x0_lsu_ready got %b want 1", lsu_ready); else n_pass++;
    tick();
    idle();
    n_checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd4 || rf_rd_data !== 32'hAA55)
      $display("FAIL x0_lsu_write got we=%b rd=%0d data=%h want 1/4/aa55", rf_we, rf_rd, rf_rd_data); else n_pass++;
    issue_long(20);
    n_checks++; if (busy !== 32'h0010_0200) $display("FAIL pre_reset_busy got %h want 00100200", busy); else n_pass++;
    rst = 1;
    tick();
    rst = 0;
    n_checks++; if (busy !== 32'd0 || rf_we !== 1'b0 || err !== 1'b0)
      $display("FAIL mid_reset got busy=%h we=%b err=%b want 0/0/0", busy, rf_we, err); else n_pass++;
  endtask

  task automatic test_random();
    bit [31:0] m_busy;
    bit        m_we, m_err;
    bit [4:0]  m_rd;
    bit [31:0] m_data;
    int        m_wait;
    bit        pend;
    bit        e_eff, e_ready, e_xfer, e_hold, e_stall;
    logic [4:0] srcs[2];
    do_reset();
    m_busy = 0; m_we = 0; m_err = 0; m_rd = 0; m_data = 0; m_wait = 0; pend = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_long  = $urandom_range(0, 1);
      iss_rd    = 5'($urandom_range(0, 15));
      dec_valid = $urandom_range(0, 1);
      dec_long  = $urandom_range(0, 1);
      dec_rs1   = 5'($urandom_range(0, 15));
      dec_rs2   = 5'($urandom_range(0, 15));
      dec_rd    = 5'($urandom_range(0, 15));
      if (!pend && $urandom_range(0, 1) == 1) begin
        pend = 1;
        lsu_rd = 5'($urandom_range(0, 15));
        for (int k = 0; k < 8 && !m_busy[lsu_rd] && lsu_rd != 0; k++)
          lsu_rd = 5'($urandom_range(1, 15));
        lsu_data = $urandom;
      end
      lsu_valid = pend;
      e_hold = pend && (m_wait == STARVE_LIMIT);
      alu_we   = e_hold ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 9) < 7);
      alu_rd   = 5'($urandom_range(0, 15));
      alu_data = $urandom;
      #1;
      e_eff   = alu_we && alu_rd != 0;
      e_ready = !e_eff;
      e_xfer  = lsu_valid && e_ready;
      srcs[0] = dec_rs1; srcs[1] = dec_rs2;
      e_stall = 0;
      foreach (srcs[s])
        if (srcs[s] != 0 && (m_busy[srcs[s]] || (m_we && m_rd == srcs[s]))) e_stall = 1;
      if (dec_long && dec_rd != 0 && m_busy[dec_rd]) e_stall = 1;
      e_stall = e_stall && dec_valid;
      n_checks++; if (lsu_ready !== e_ready) $display("FAIL rnd%0d_lsu_ready got %b want %b", cyc, lsu_ready, e_ready); else n_pass++;
      n_checks++; if (alu_hold !== e_hold) $display("FAIL rnd%0d_alu_hold got %b want %b", cyc, alu_hold, e_hold); else n_pass++;
      n_checks++; if (dec_stall !== e_stall) $display("FAIL rnd%0d_dec_stall got %b want %b", cyc, dec_stall, e_stall); else n_pass++;
      if ((e_eff && e_hold) || (e_xfer && lsu_rd != 0 && !m_busy[lsu_rd])) m_err = 1;
      if (e_eff) begin
        m_we = 1; m_rd = alu_rd; m_data = alu_data;
      end else if (e_xfer) begin
        m_we = 1; m_rd = lsu_rd; m_data = lsu_data;
      end else begin
        m_we = 0;
      end
      if (e_xfer) m_busy[lsu_rd] = 0;
      if (iss_valid && iss_long && iss_rd != 0) m_busy[iss_rd] = 1;
      if (!lsu_valid || e_xfer) m_wait = 0;
      else if (m_wait < STARVE_LIMIT) m_wait++;
      if (e_xfer) pend = 0;
      tick();
      n_checks++; if (rf_we !== m_we || rf_rd !== m_rd || rf_rd_data !== m_data)
        $display("FAIL rnd%0d_rf got %b/%0d/%h want %b/%0d/%h", cyc, rf_we, rf_rd, rf_rd_data, m_we, m_rd, m_data); else n_pass++;
      n_checks++; if (busy !== m_busy) $display("FAIL rnd%0d_busy got %h want %h", cyc, busy, m_busy); else n_pass++;
      n_checks++; if (err !== m_err) $display("FAIL rnd%0d_err got %b want %b", cyc, err, m_err); else n_pass++;
    end
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_alu_write();
    test_long_op();
    test_starvation();
    test_set_wins_err();
    test_x0_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
